// File: rtl/heap_pq_engine.sv
//------------------------------------------------------------------------------
// heap_pq_engine
//
// Binary-heap priority queue with a configurable element width, capacity and
// ordering. Elements are first streamed in unordered. Commands then build the
// heap, extract the root, insert, increase a key, or stream the heap contents
// out to a RAM write-back port.
//
// Optional feature macro: HEAP_PQ_PEEK_EN
//   defined   -> cmd 5 returns the root on out_data without changing the heap
//   undefined -> cmd 5 is an illegal command and pulses err
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   data_valid  load strobe, one element per cycle while idle
//   data        element to load
//   cmd_valid   command request, accepted when idle and data_valid=0
//   cmd         0 build, 1 extract, 2 increase-key, 3 insert, 4 write-RAM
//   index       target slot for increase-key
//   value       key for increase-key and insert
//   busy        high while a command executes
//   RAM_valid   RAM_A/RAM_D carry a write-back beat this cycle
//   RAM_A       write-back address
//   RAM_D       write-back data
//   done        one-cycle pulse after the last write-back beat
//   out_valid   one-cycle pulse, out_data holds the extracted/peeked root
//   out_data    root value returned by extract (or peek)
//   err         one-cycle pulse on an illegal request
//   count       current number of elements in the heap
//------------------------------------------------------------------------------
module heap_pq_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int IDX_W      = 8,
   parameter int MIN_HEAP   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  cmd_valid,
   input  logic [2:0]            cmd,
   input  logic [IDX_W-1:0]      index,
   input  logic [DATA_WIDTH-1:0] value,
   output logic                  busy,
   output logic                  RAM_valid,
   output logic [IDX_W-1:0]      RAM_A,
   output logic [DATA_WIDTH-1:0] RAM_D,
   output logic                  done,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  err,
   output logic [IDX_W-1:0]      count
);

   localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

   localparam logic [2:0] CMD_BUILD   = 3'd0;
   localparam logic [2:0] CMD_EXTRACT = 3'd1;
   localparam logic [2:0] CMD_INCKEY  = 3'd2;
   localparam logic [2:0] CMD_INSERT  = 3'd3;
   localparam logic [2:0] CMD_WRITE   = 3'd4;
`ifdef HEAP_PQ_PEEK_EN
   localparam logic [2:0] CMD_PEEK    = 3'd5;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_BUILD, S_SD_CMP, S_SD_SWAP, S_SU_STEP, S_WRITE, S_FINISH
   } state_t;

   state_t state_reg, state_next;

   // Heap storage; contents are don't-care after reset so no reset is applied.
   logic [DATA_WIDTH-1:0] heap_mem [DEPTH];

   logic [IDX_W-1:0]      count_reg;
   logic [IDX_W-1:0]      i_reg;        // node currently being sifted
   logic [IDX_W-1:0]      j_reg;        // next build start node
   logic [IDX_W-1:0]      best_reg;     // child chosen by SD_CMP
   logic [IDX_W-1:0]      a_reg;        // write-back address
   logic [2:0]            op_reg;       // command in progress
   logic                  err_reg;
   logic                  out_valid_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;

   function automatic logic [AW-1:0] slot(input logic [IDX_W-1:0] x);
      return x[AW-1:0];
   endfunction

   // Strict ordering: equal keys never count as better, so ties never swap.
   function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
      if (MIN_HEAP != 0) return a < b;
      else               return a > b;
   endfunction

   //---------------------------------------------------------------------------
   // Request decode
   //---------------------------------------------------------------------------
   logic accept;
   logic load_fire;
   logic load_ok;
   logic cmd_err;
   logic key_better;

   always_comb begin
      load_fire  = (state_reg == S_IDLE) && data_valid;
      load_ok    = load_fire && (count_reg < DEPTH_I);
      accept     = (state_reg == S_IDLE) && cmd_valid && !data_valid;
      key_better = better(value, heap_mem[slot(index)]);
      cmd_err    = 1'b0;
      case (cmd)
         CMD_BUILD:   cmd_err = 1'b0;
         CMD_EXTRACT: cmd_err = (count_reg == '0);
         CMD_INCKEY:  cmd_err = (index >= count_reg);
         CMD_INSERT:  cmd_err = (count_reg == DEPTH_I);
         CMD_WRITE:   cmd_err = 1'b0;
`ifdef HEAP_PQ_PEEK_EN
         CMD_PEEK:    cmd_err = (count_reg == '0);
`endif
         default:     cmd_err = 1'b1;
      endcase
   end

   //---------------------------------------------------------------------------
   // Sift-down compare and sift-up compare
   //---------------------------------------------------------------------------
   logic [IDX_W:0]        left_w;
   logic [IDX_W:0]        right_w;
   logic [IDX_W-1:0]      sd_best;
   logic [DATA_WIDTH-1:0] sd_best_val;
   logic [IDX_W-1:0]      parent_idx;
   logic                  su_swap;

   always_comb begin
      // Child indices need one extra bit: 2i+2 can exceed the index range.
      left_w      = {i_reg, 1'b1};
      right_w     = {i_reg, 1'b0} + (IDX_W+1)'(2);
      sd_best     = i_reg;
      sd_best_val = heap_mem[slot(i_reg)];
      if ((left_w < {1'b0, count_reg}) &&
          better(heap_mem[slot(left_w[IDX_W-1:0])], sd_best_val)) begin
         sd_best     = left_w[IDX_W-1:0];
         sd_best_val = heap_mem[slot(left_w[IDX_W-1:0])];
      end
      if ((right_w < {1'b0, count_reg}) &&
          better(heap_mem[slot(right_w[IDX_W-1:0])], sd_best_val)) begin
         sd_best     = right_w[IDX_W-1:0];
         sd_best_val = heap_mem[slot(right_w[IDX_W-1:0])];
      end
      parent_idx = (i_reg - IDX_W'(1)) >> 1;
      su_swap    = (i_reg != '0) &&
                   better(heap_mem[slot(i_reg)], heap_mem[slot(parent_idx)]);
   end

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   //---------------------------------------------------------------------------
   // FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (cmd_err) begin
                  state_next = S_FINISH;
               end else begin
                  case (cmd)
                     CMD_BUILD:   state_next = (count_reg < IDX_W'(2)) ? S_FINISH : S_BUILD;
                     CMD_EXTRACT: state_next = S_SD_CMP;
                     CMD_INCKEY:  state_next = key_better ? S_SU_STEP : S_FINISH;
                     CMD_INSERT:  state_next = S_SU_STEP;
                     CMD_WRITE:   state_next = (count_reg == '0) ? S_FINISH : S_WRITE;
                     default:     state_next = S_FINISH;   // peek
                  endcase
               end
            end
         end
         S_BUILD:   state_next = S_SD_CMP;
         S_SD_CMP: begin
            if (sd_best != i_reg)
               state_next = S_SD_SWAP;
            else if ((op_reg == CMD_BUILD) && (j_reg != '0))
               state_next = S_BUILD;
            else
               state_next = S_FINISH;
         end
         S_SD_SWAP: state_next = S_SD_CMP;
         S_SU_STEP: state_next = su_swap ? S_SU_STEP : S_FINISH;
         S_WRITE:   state_next = (a_reg == count_reg - IDX_W'(1)) ? S_FINISH : S_WRITE;
         S_FINISH:  state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs
   //---------------------------------------------------------------------------
   always_comb begin
      busy      = (state_reg != S_IDLE);
      RAM_valid = (state_reg == S_WRITE);
      // Address/data are forced to zero outside write-back beats.
      RAM_A     = RAM_valid ? a_reg : '0;
      RAM_D     = RAM_valid ? heap_mem[slot(a_reg)] : '0;
      done      = (state_reg == S_FINISH) && (op_reg == CMD_WRITE);
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign err       = err_reg;
   assign count     = count_reg;

   //---------------------------------------------------------------------------
   // Heap write ports: port 0 serves loads/commands/swaps, port 1 the
   // second half of a swap.
   //---------------------------------------------------------------------------
   logic                  we0, we1;
   logic [IDX_W-1:0]      wa0, wa1;
   logic [DATA_WIDTH-1:0] wd0, wd1;

   always_comb begin
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      if (load_ok) begin
         we0 = 1'b1; wa0 = count_reg; wd0 = data;
      end else if (accept && !cmd_err) begin
         case (cmd)
            CMD_EXTRACT: begin
               // Last element moves to the root before sifting down.
               we0 = 1'b1; wa0 = '0;
               wd0 = heap_mem[slot(count_reg - IDX_W'(1))];
            end
            CMD_INSERT: begin
               we0 = 1'b1; wa0 = count_reg; wd0 = value;
            end
            CMD_INCKEY: begin
               we0 = key_better; wa0 = index; wd0 = value;
            end
            default: ;
         endcase
      end
      if (state_reg == S_SD_SWAP) begin
         we0 = 1'b1; wa0 = i_reg;    wd0 = heap_mem[slot(best_reg)];
         we1 = 1'b1; wa1 = best_reg; wd1 = heap_mem[slot(i_reg)];
      end
      if ((state_reg == S_SU_STEP) && su_swap) begin
         we0 = 1'b1; wa0 = i_reg;      wd0 = heap_mem[slot(parent_idx)];
         we1 = 1'b1; wa1 = parent_idx; wd1 = heap_mem[slot(i_reg)];
      end
   end

   always_ff @(posedge clk) begin
      if (we0) heap_mem[slot(wa0)] <= wd0;
      if (we1) heap_mem[slot(wa1)] <= wd1;
   end

   //---------------------------------------------------------------------------
   // Control datapath
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg     <= '0;
         i_reg         <= '0;
         j_reg         <= '0;
         best_reg      <= '0;
         a_reg         <= '0;
         op_reg        <= '0;
         err_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         err_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (load_fire) begin
                  if (load_ok) count_reg <= count_reg + IDX_W'(1);
                  else         err_reg   <= 1'b1;
               end else if (accept) begin
                  op_reg <= cmd;
                  a_reg  <= '0;
                  if (cmd_err) begin
                     err_reg <= 1'b1;
                  end else begin
                     case (cmd)
                        // Last internal node; unused when count < 2.
                        CMD_BUILD: j_reg <= (count_reg >> 1) - IDX_W'(1);
                        CMD_EXTRACT: begin
                           out_data_reg  <= heap_mem[0];
                           out_valid_reg <= 1'b1;
                           count_reg     <= count_reg - IDX_W'(1);
                           i_reg         <= '0;
                        end
                        CMD_INCKEY: i_reg <= index;
                        CMD_INSERT: begin
                           i_reg     <= count_reg;
                           count_reg <= count_reg + IDX_W'(1);
                        end
`ifdef HEAP_PQ_PEEK_EN
                        CMD_PEEK: begin
                           out_data_reg  <= heap_mem[0];
                           out_valid_reg <= 1'b1;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            S_BUILD: i_reg <= j_reg;
            S_SD_CMP: begin
               if (sd_best != i_reg)
                  best_reg <= sd_best;
               else if ((op_reg == CMD_BUILD) && (j_reg != '0))
                  j_reg <= j_reg - IDX_W'(1);
            end
            S_SD_SWAP: i_reg <= best_reg;
            S_SU_STEP: if (su_swap) i_reg <= parent_idx;
            S_WRITE:   a_reg <= a_reg + IDX_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_heap_pq_engine.sv
//------------------------------------------------------------------------------
// tb_heap_pq_engine
//
// Drives a max-heap and a min-heap instance with identical stimulus and checks
// both against an array-based priority-queue model. Directed sequences first,
// then randomized loads and commands.
//------------------------------------------------------------------------------
module tb_heap_pq_engine;

   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int IW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          data_valid = 1'b0;
   logic [DW-1:0] data       = '0;
   logic          cmd_valid  = 1'b0;
   logic [2:0]    cmd        = '0;
   logic [IW-1:0] index      = '0;
   logic [DW-1:0] value      = '0;

   logic [1:0]         busy_o, ram_valid_o, done_o, out_valid_o, err_o;
   logic [1:0][IW-1:0] ram_a_o, count_o;
   logic [1:0][DW-1:0] ram_d_o, out_data_o;

   // Instance 0 is a max-heap, instance 1 a min-heap.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      heap_pq_engine #(
         .DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IW), .MIN_HEAP(gi)
      ) dut (
         .clk(clk), .rst(rst),
         .data_valid(data_valid), .data(data),
         .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
         .busy(busy_o[gi]), .RAM_valid(ram_valid_o[gi]), .RAM_A(ram_a_o[gi]),
         .RAM_D(ram_d_o[gi]), .done(done_o[gi]), .out_valid(out_valid_o[gi]),
         .out_data(out_data_o[gi]), .err(err_o[gi]), .count(count_o[gi])
      );
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, required %0d", tag, obs, exp);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: plain arrays, textbook heap operations
   //---------------------------------------------------------------------------
   int mh [2][DEPTH];
   int mcnt [2];
   int e_err [2], e_ov [2], e_od [2], e_done [2], e_nram [2], e_cyc [2];
   int plan_od [2];
   int plan_ram0 [$];
   int plan_ram1 [$];

   function automatic bit mbetter(input int k, input int a, input int b);
      return (k == 1) ? (a < b) : (a > b);
   endfunction

   task automatic m_swap(input int k, input int a, input int b);
      int t;
      t = mh[k][a]; mh[k][a] = mh[k][b]; mh[k][b] = t;
   endtask

   task automatic m_sift_down(input int k, input int start);
      int i, l, r, b;
      i = start;
      while (1) begin
         l = 2 * i + 1; r = 2 * i + 2; b = i;
         if (l < mcnt[k] && mbetter(k, mh[k][l], mh[k][b])) b = l;
         if (r < mcnt[k] && mbetter(k, mh[k][r], mh[k][b])) b = r;
         if (b == i) break;
         m_swap(k, i, b);
         i = b;
      end
   endtask

   task automatic m_sift_up(input int k, input int start);
      int i, p;
      i = start;
      while (i > 0) begin
         p = (i - 1) / 2;
         if (!mbetter(k, mh[k][i], mh[k][p])) break;
         m_swap(k, i, p);
         i = p;
      end
   endtask

   task automatic m_cmd(input int k, input int c, input int idx, input int val);
      e_err[k] = 0; e_ov[k] = 0; e_od[k] = 0; e_done[k] = 0; e_nram[k] = 0; e_cyc[k] = -1;
      case (c)
         0: for (int j = mcnt[k] / 2 - 1; j >= 0; j--) m_sift_down(k, j);
         1: begin
            if (mcnt[k] == 0) begin
               e_err[k] = 1; e_cyc[k] = 1;
            end else begin
               e_ov[k] = 1; e_od[k] = mh[k][0];
               mh[k][0] = mh[k][mcnt[k] - 1];
               mcnt[k]--;
               m_sift_down(k, 0);
            end
         end
         2: begin
            if (idx >= mcnt[k]) e_err[k] = 1;
            else if (mbetter(k, val, mh[k][idx])) begin
               mh[k][idx] = val;
               m_sift_up(k, idx);
            end
         end
         3: begin
            if (mcnt[k] == DEPTH) e_err[k] = 1;
            else begin
               mh[k][mcnt[k]] = val;
               mcnt[k]++;
               m_sift_up(k, mcnt[k] - 1);
            end
         end
         4: begin
            e_done[k] = 1; e_nram[k] = mcnt[k]; e_cyc[k] = mcnt[k] + 1;
         end
`ifdef HEAP_PQ_PEEK_EN
         5: begin
            e_cyc[k] = 1;
            if (mcnt[k] == 0) e_err[k] = 1;
            else begin
               e_ov[k] = 1; e_od[k] = mh[k][0];
            end
         end
`endif
         default: e_err[k] = 1;
      endcase
   endtask

   //---------------------------------------------------------------------------
   // Stimulus tasks
   //---------------------------------------------------------------------------
   task automatic do_load(input int d, input bit with_cmd);
      int exp_err [2];
      @(negedge clk);
      data_valid = 1'b1; data = DW'(d);
      cmd_valid = with_cmd; cmd = 3'd1;
      for (int k = 0; k < 2; k++) begin
         if (mcnt[k] < DEPTH) begin
            mh[k][mcnt[k]] = d; mcnt[k]++; exp_err[k] = 0;
         end else exp_err[k] = 1;
      end
      @(posedge clk); #1;
      data_valid = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("load_err%0d", k), int'(err_o[k]), exp_err[k]);
         check($sformatf("load_busy%0d", k), int'(busy_o[k]), 0);
         check($sformatf("load_ov%0d", k), int'(out_valid_o[k]), 0);
         check($sformatf("load_count%0d", k), int'(count_o[k]), mcnt[k]);
      end
      $display("load data=%0d cmd_also=%0d count=%0d err=%0d", d, with_cmd, count_o[0], err_o[0]);
   endtask

   task automatic run_cmd(input int c, input int idx, input int val);
      int err_n [2], ov_n [2], od [2], done_n [2], ram_n [2], cyc [2];
      int ramd [2][64];
      int rama [2][64];
      bit fin [2];
      for (int k = 0; k < 2; k++) begin
         m_cmd(k, c, idx, val);
         err_n[k] = 0; ov_n[k] = 0; od[k] = 0; done_n[k] = 0; ram_n[k] = 0; cyc[k] = 0; fin[k] = 0;
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd = 3'(c); index = IW'(idx); value = DW'(val);
      @(posedge clk); #1;
      // Garbage on the command inputs while busy must be ignored.
      cmd_valid = 1'b0; cmd = 3'($urandom_range(0, 7));
      index = IW'($urandom); value = DW'($urandom);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!fin[k]) begin
               if (t == 0) check($sformatf("busy_t1_%0d", k), int'(busy_o[k]), 1);
               if (err_o[k]) err_n[k]++;
               if (out_valid_o[k]) begin ov_n[k]++; od[k] = int'(out_data_o[k]); end
               if (done_o[k]) done_n[k]++;
               if (ram_valid_o[k]) begin
                  if (ram_n[k] < 64) begin
                     rama[k][ram_n[k]] = int'(ram_a_o[k]);
                     ramd[k][ram_n[k]] = int'(ram_d_o[k]);
                  end
                  ram_n[k]++;
               end
               if (!busy_o[k]) fin[k] = 1;
               else            cyc[k]++;
            end
         end
         if (fin[0] && fin[1]) break;
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("cmd%0d_timeout%0d", c, k), int'(fin[k]), 1);
         check($sformatf("cmd%0d_err%0d", c, k), err_n[k], e_err[k]);
         check($sformatf("cmd%0d_outvalid%0d", c, k), ov_n[k], e_ov[k]);
         if (e_ov[k] != 0) check($sformatf("cmd%0d_outdata%0d", c, k), od[k], e_od[k]);
         if (e_ov[k] != 0 && plan_od[k] >= 0)
            check($sformatf("plan_outdata%0d", k), od[k], plan_od[k]);
         check($sformatf("cmd%0d_done%0d", c, k), done_n[k], e_done[k]);
         check($sformatf("cmd%0d_nram%0d", c, k), ram_n[k], e_nram[k]);
         for (int a = 0; a < e_nram[k] && a < ram_n[k] && a < 64; a++) begin
            check($sformatf("ram_a%0d_%0d", k, a), rama[k][a], a);
            check($sformatf("ram_d%0d_%0d", k, a), ramd[k][a], mh[k][a]);
         end
         if (e_cyc[k] >= 0) check($sformatf("cmd%0d_busycyc%0d", c, k), cyc[k], e_cyc[k]);
         check($sformatf("cmd%0d_count%0d", c, k), int'(count_o[k]), mcnt[k]);
      end
      if (plan_ram0.size() > 0) begin
         check("plan_nram0", ram_n[0], plan_ram0.size());
         for (int a = 0; a < plan_ram0.size() && a < ram_n[0]; a++)
            check($sformatf("plan_ram0_%0d", a), ramd[0][a], plan_ram0[a]);
      end
      if (plan_ram1.size() > 0) begin
         check("plan_nram1", ram_n[1], plan_ram1.size());
         for (int a = 0; a < plan_ram1.size() && a < ram_n[1]; a++)
            check($sformatf("plan_ram1_%0d", a), ramd[1][a], plan_ram1[a]);
      end
      plan_ram0.delete(); plan_ram1.delete();
      plan_od[0] = -1; plan_od[1] = -1;
      $display("cmd=%0d idx=%0d val=%0d err=%0d/%0d out=%0d/%0d beats=%0d/%0d count=%0d/%0d",
               c, idx, val, err_n[0], err_n[1], od[0], od[1], ram_n[0], ram_n[1],
               count_o[0], count_o[1]);
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_busy%0d", tag, k), int'(busy_o[k]), 0);
         check($sformatf("%s_ramvalid%0d", tag, k), int'(ram_valid_o[k]), 0);
         check($sformatf("%s_rama%0d", tag, k), int'(ram_a_o[k]), 0);
         check($sformatf("%s_ramd%0d", tag, k), int'(ram_d_o[k]), 0);
         check($sformatf("%s_done%0d", tag, k), int'(done_o[k]), 0);
         check($sformatf("%s_outvalid%0d", tag, k), int'(out_valid_o[k]), 0);
         check($sformatf("%s_outdata%0d", tag, k), int'(out_data_o[k]), 0);
         check($sformatf("%s_err%0d", tag, k), int'(err_o[k]), 0);
         check($sformatf("%s_count%0d", tag, k), int'(count_o[k]), 0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      mcnt[0] = 0; mcnt[1] = 0;
      $display("reset applied");
   endtask

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      int vals [8];
      int r, c, idx, val;
      plan_od[0] = -1; plan_od[1] = -1;
      mcnt[0] = 0; mcnt[1] = 0;

      do_reset();

      // Max build / extract / insert / increase-key example
      vals = '{3, 1, 4, 1, 5, 9, 2, 6};
      for (int n = 0; n < 8; n++) do_load(vals[n], 1'b0);
      run_cmd(0, 0, 0);
      plan_ram0 = '{9, 6, 4, 1, 5, 3, 2, 1};
      run_cmd(4, 0, 0);
      plan_od[0] = 9;
      run_cmd(1, 0, 0);
      plan_ram0 = '{6, 5, 4, 1, 1, 3, 2};
      run_cmd(4, 0, 0);
      run_cmd(3, 0, 7);
      plan_ram0 = '{7, 6, 4, 5, 1, 3, 2, 1};
      run_cmd(4, 0, 0);
      run_cmd(2, 6, 8);
      plan_ram0 = '{8, 6, 7, 5, 1, 3, 4, 1};
      run_cmd(4, 0, 0);
      run_cmd(2, 6, 0);
      run_cmd(4, 0, 0);
      run_cmd(2, 9, 100);                  // index beyond count
      run_cmd(6, 0, 0);                    // illegal
      run_cmd(7, 0, 0);
      run_cmd(5, 0, 0);                    // peek or illegal

      // Drain to empty, then boundary commands on an empty heap
      while (mcnt[0] > 0) run_cmd(1, 0, 0);
      run_cmd(1, 0, 0);
      run_cmd(4, 0, 0);
      run_cmd(0, 0, 0);
      run_cmd(5, 0, 0);

      // data_valid wins over a simultaneous command
      do_load(42, 1'b1);

      // Reset in the middle of a build
      for (int n = 0; n < 10; n++) do_load($urandom_range(0, 50), 1'b0);
      @(negedge clk); cmd_valid = 1'b1; cmd = 3'd0;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero("midbuild_rst");
      @(negedge clk); rst = 1'b1;
      mcnt[0] = 0; mcnt[1] = 0;
      $display("reset during build");

      // Min-heap example (both instances see it)
      do_load(5, 1'b0); do_load(3, 1'b0); do_load(8, 1'b0);
      run_cmd(0, 0, 0);
      plan_od[0] = 8; plan_od[1] = 3;
      run_cmd(1, 0, 0);
      plan_ram0 = '{5, 3}; plan_ram1 = '{5, 8};
      run_cmd(4, 0, 0);
`ifdef HEAP_PQ_PEEK_EN
      plan_od[0] = 5; plan_od[1] = 5;
`endif
      run_cmd(5, 0, 0);

      // Capacity boundary
      do_reset();
      for (int n = 0; n < DEPTH; n++) do_load($urandom_range(0, 255), 1'b0);
      do_load(77, 1'b0);                   // dropped, err
      run_cmd(3, 0, 9);                    // insert on full heap
      run_cmd(0, 0, 0);
      run_cmd(4, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         val = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
         if (r < 30) begin
            do_load(val, $urandom_range(0, 1) == 1);
         end else begin
            c = $urandom_range(0, 11);
            if (c == 8 || c == 9) c = 1;
            if (c >= 10) c = 3;
            idx = $urandom_range(0, mcnt[0] + 1);
            run_cmd(c, idx, val);
         end
      end
      run_cmd(4, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
